// File: rtl/sisc_pkg.sv
// Constants shared by the SISC fetch unit and the core decoder.
package sisc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Opcode field position inside the 32-bit instruction word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [31:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/sisc_ifetch_if.sv
// Signal bundle between the fetch unit, the instruction memory and the control unit.
//
// Handshakes:
//   imem_rd/imem_ack : imem_rd is raised with imem_addr and both are held stable
//                      until the cycle in which imem_ack=1; imem_data is valid in
//                      that cycle only. imem_ack with imem_rd=0 carries no meaning.
//   ir_valid/ir_take : ir is held with ir_valid=1 until the control unit asserts
//                      ir_take; the word is consumed on that edge. ir_take with
//                      ir_valid=0 carries no meaning.
interface sisc_ifetch_if #(
    parameter int ADDR_W = 16
);
    import sisc_pkg::*;

    logic              fetch_en;
    logic              ir_take;
    logic              br_load;
    logic              br_rel;
    logic [ADDR_W-1:0] br_addr;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_data;
    logic [31:0]       ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    fetch_state_e      state;

    // Fetch-unit side.
    modport master (
        input  fetch_en, ir_take, br_load, br_rel, br_addr, imem_ack, imem_data,
        output imem_rd, imem_addr, ir, ir_valid, pc, halted, state
    );

    // Memory / control-unit side.
    modport slave (
        output fetch_en, ir_take, br_load, br_rel, br_addr, imem_ack, imem_data,
        input  imem_rd, imem_addr, ir, ir_valid, pc, halted, state
    );

endinterface

// File: rtl/sisc_pc.sv
// Program counter: increment, absolute load or PC-relative load, wrapping at ADDR_W bits.
module sisc_pc #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              inc,
    input  logic              load,
    input  logic              rel,
    input  logic [ADDR_W-1:0] operand,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] target
);

    // Same-width add: the offset's sign extension is implicit and the sum wraps.
    assign target = rel ? (pc + operand) : operand;

    // Load has priority over increment.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/sisc_ifetch.sv
// Instruction fetch front end: owns the PC, reads IMEM over rd/ack, holds the word in IR.
module sisc_ifetch
    import sisc_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_f,
    sisc_ifetch_if.master bus
);

    fetch_state_e      state, state_n;
    logic [31:0]       ir_q, ir_n;
    logic              irv_q, irv_n;
    logic              rd_q, rd_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              halted_q, halted_n;
    logic              pend_q, pend_n;
    logic [ADDR_W-1:0] tgt_q, tgt_n;

    logic              pc_inc, pc_load, pc_rel, use_pend;
    logic [ADDR_W-1:0] pc_opnd, pc_q, pc_tgt;

    // A latched redirect is applied only when no fresh branch arrives with the ACK.
    assign use_pend = pend_q && !bus.br_load;
    assign pc_rel   = use_pend ? 1'b0 : bus.br_rel;
    assign pc_opnd  = use_pend ? tgt_q : bus.br_addr;

    sisc_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_f   (rst_f),
        .inc     (pc_inc),
        .load    (pc_load),
        .rel     (pc_rel),
        .operand (pc_opnd),
        .pc      (pc_q),
        .target  (pc_tgt)
    );

    assign bus.ir        = ir_q;
    assign bus.ir_valid  = irv_q;
    assign bus.imem_rd   = rd_q;
    assign bus.imem_addr = addr_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.state     = state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state, register updates and PC controls.
    always_comb begin
        state_n  = state;
        ir_n     = ir_q;
        irv_n    = irv_q;
        rd_n     = rd_q;
        addr_n   = addr_q;
        halted_n = halted_q;
        pend_n   = pend_q;
        tgt_n    = tgt_q;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                pc_load = bus.br_load;
                if (bus.fetch_en && !halted_q) begin
                    state_n = ST_REQ;
                    rd_n    = 1'b1;
                    addr_n  = bus.br_load ? pc_tgt : pc_q;
                end
            end
            ST_REQ: begin
                if (!rd_q) begin
                    // One-cycle gap after a squashed fetch: reissue at the (possibly new) PC.
                    pc_load = bus.br_load;
                    rd_n    = 1'b1;
                    addr_n  = bus.br_load ? pc_tgt : pc_q;
                end else if (bus.imem_ack) begin
                    rd_n = 1'b0;
                    if (bus.br_load || pend_q) begin
                        pc_load = 1'b1;
                        pend_n  = 1'b0;
                    end else begin
                        ir_n    = bus.imem_data;
                        irv_n   = 1'b1;
                        pc_inc  = 1'b1;
                        state_n = ST_VALID;
                    end
                end else if (bus.br_load) begin
                    pend_n = 1'b1;
                    tgt_n  = pc_tgt;
                end
            end
            ST_VALID: begin
                pc_load = bus.br_load;
                if (bus.ir_take) begin
                    irv_n = 1'b0;
                    if (opcode_of(ir_q) == OP_HALT) begin
                        state_n  = ST_HALT;
                        halted_n = 1'b1;
                    end else if (bus.fetch_en) begin
                        state_n = ST_REQ;
                        rd_n    = 1'b1;
                        addr_n  = bus.br_load ? pc_tgt : pc_q;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_HALT: begin
                state_n = ST_HALT;
            end
        endcase
    end

    // Datapath registers: IR, memory request, halt flag and pending redirect.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ir_q     <= 32'h0;
            irv_q    <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            halted_q <= 1'b0;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
        end else begin
            ir_q     <= ir_n;
            irv_q    <= irv_n;
            rd_q     <= rd_n;
            addr_q   <= addr_n;
            halted_q <= halted_n;
            pend_q   <= pend_n;
            tgt_q    <= tgt_n;
        end
    end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: behavioural IMEM, random control unit, scoreboard on IR/PC.
module tb_sisc_ifetch;
    import sisc_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_f;
    always #5 clk = ~clk;

    sisc_ifetch_if #(.ADDR_W(16)) bus ();

    sisc_ifetch #(
        .ADDR_W   (16),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural instruction memory ----------------
    logic [31:0] mem [logic [15:0]];
    int          ack_delay  = 0;
    bit          rand_delay = 0;
    bit          force_ack  = 0;
    int          wait_cnt   = 0;
    int          cur_delay  = 0;
    logic [15:0] req_addr;

    function automatic logic [31:0] word_at(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return {1'b0, a[2:0], 12'h5A5, a};
    endfunction

    // Acknowledges 1 + wait-states cycles after the request appears; checks address stability.
    always @(negedge clk) begin
        logic ack;
        ack = 1'b0;
        bus.imem_data = $urandom;
        if (bus.imem_rd && rst_f) begin
            if (wait_cnt == 0) begin
                req_addr  = bus.imem_addr;
                cur_delay = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
            end else begin
                check("imem_addr_stable", bus.imem_addr, req_addr);
            end
            if (wait_cnt >= cur_delay + 1) begin
                ack = 1'b1;
                bus.imem_data = word_at(bus.imem_addr);
            end
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        bus.imem_ack = ack | force_ack;
    end

    // ---------------- control unit: consumes IR with a set probability ----------------
    int take_pct = 100;
    always @(negedge clk) bus.ir_take = ($urandom_range(0, 99) < take_pct);

    // ---------------- reference model: predicts each delivered word ----------------
    logic [47:0] exp_q [$];
    logic [15:0] m_pc, m_tgt;
    bit          m_pend;

    always @(negedge clk) begin
        logic [15:0] tgt;
        #1;
        if (!rst_f) begin
            m_pc   = RESET_PC;
            m_pend = 1'b0;
            exp_q.delete();
        end else begin
            tgt = bus.br_rel ? m_pc + bus.br_addr : bus.br_addr;
            if (bus.imem_rd && bus.imem_ack) begin
                if (bus.br_load) begin
                    m_pc   = tgt;
                    m_pend = 1'b0;
                end else if (m_pend) begin
                    m_pc   = m_tgt;
                    m_pend = 1'b0;
                end else begin
                    check("fetch_addr", bus.imem_addr, m_pc);
                    exp_q.push_back({word_at(m_pc), m_pc + 16'd1});
                    m_pc = m_pc + 16'd1;
                end
            end else if (bus.br_load) begin
                if (bus.imem_rd) begin
                    m_pend = 1'b1;
                    m_tgt  = tgt;
                end else begin
                    m_pc = tgt;
                end
            end
        end
    end

    // ---------------- monitor: compares every newly valid IR ----------------
    bit prev_valid = 1'b0;
    bit prev_ack   = 1'b0;

    always @(negedge clk) begin
        logic [47:0] e;
        #1;
        if (!rst_f) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (bus.ir_valid && !prev_valid) begin
                check("valid_after_ack", 32'(prev_ack), 32'd1);
                if (exp_q.size() == 0) begin
                    check("sb_expected_word", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("ir", bus.ir, e[47:16]);
                    check("pc_after_fetch", 32'(bus.pc), 32'(e[15:0]));
                end
            end
            prev_valid = bus.ir_valid;
            prev_ack   = bus.imem_ack && bus.imem_rd;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_f        = 1'b0;
        bus.fetch_en = 1'b0;
        bus.br_load  = 1'b0;
        repeat (2) @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic branch(input logic rel, input logic [15:0] addr);
        @(negedge clk);
        bus.br_load = 1'b1;
        bus.br_rel  = rel;
        bus.br_addr = addr;
        @(negedge clk);
        bus.br_load = 1'b0;
    endtask

    // Cycles until the next rising edge of imem_rd, or -1 on timeout.
    task automatic wait_rd_rise(input int limit, output int n);
        logic last;
        last = bus.imem_rd;
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            n++;
            if (bus.imem_rd && !last) return;
            last = bus.imem_rd;
        end
        n = -1;
    endtask

    task automatic wait_ir_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.ir_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        bit ok;
        rst_f        = 1'b0;
        bus.fetch_en = 1'b0;
        bus.br_load  = 1'b0;
        bus.br_rel   = 1'b0;
        bus.br_addr  = 16'h0;

        // 1: reset with an ACK pulse that must be ignored
        @(posedge clk); force_ack = 1'b1;
        @(posedge clk); force_ack = 1'b0;
        @(negedge clk);
        check("rst_ir", bus.ir, 32'h0);
        check("rst_ir_valid", 32'(bus.ir_valid), 32'd0);
        check("rst_imem_rd", 32'(bus.imem_rd), 32'd0);
        check("rst_pc", 32'(bus.pc), 32'(RESET_PC));
        check("rst_halted", 32'(bus.halted), 32'd0);
        rst_f = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_rd", 32'(bus.imem_rd), 32'd0);
        check("post_rst_valid", 32'(bus.ir_valid), 32'd0);

        // 2: back-to-back fetch with no wait states
        mem[16'h0000] = 32'h8801_0001;
        mem[16'h0001] = 32'h8011_2001;
        ack_delay = 0;
        take_pct  = 100;
        @(negedge clk);
        bus.fetch_en = 1'b1;
        wait_rd_rise(10, n);
        check("first_req", 32'(n), 32'd1);
        check("first_req_addr", 32'(bus.imem_addr), 32'h0);
        wait_rd_rise(20, n);
        check("req_to_req", 32'(n), 32'd3);
        bus.fetch_en = 1'b0;
        repeat (10) @(negedge clk);

        // 3: three wait states
        do_reset();
        ack_delay    = 3;
        bus.fetch_en = 1'b1;
        repeat (40) @(negedge clk);
        bus.fetch_en = 1'b0;
        repeat (12) @(negedge clk);

        // 4: absolute branch while the fetch of address 5 is outstanding
        do_reset();
        mem[16'h0040] = 32'h8040_ABCD;
        ack_delay     = 3;
        bus.fetch_en  = 1'b1;
        n = 0;
        while (!(bus.imem_rd && bus.imem_addr == 16'h0005) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_pc5", 32'(n < 200), 32'd1);
        bus.br_load = 1'b1;
        bus.br_rel  = 1'b0;
        bus.br_addr = 16'h0040;
        @(negedge clk);
        bus.br_load = 1'b0;
        wait_rd_rise(30, n);
        check("squash_reissue", 32'(n > 0), 32'd1);
        check("squash_addr", 32'(bus.imem_addr), 32'h0040);
        wait_ir_valid(30, ok);
        check("squash_delivered", 32'(ok), 32'd1);
        check("squash_ir", bus.ir, 32'h8040_ABCD);
        check("squash_pc", 32'(bus.pc), 32'h0041);
        bus.fetch_en = 1'b0;
        repeat (15) @(negedge clk);

        // 5: relative branch wrap and PC wrap on fetch
        do_reset();
        ack_delay = 0;
        branch(1'b0, 16'hFFFE);
        branch(1'b1, 16'h0003);
        check("rel_wrap_pc", 32'(bus.pc), 32'h0001);
        branch(1'b0, 16'hFFFF);
        check("abs_pc", 32'(bus.pc), 32'hFFFF);
        bus.fetch_en = 1'b1;
        wait_ir_valid(20, ok);
        check("wrap_delivered", 32'(ok), 32'd1);
        check("wrap_pc", 32'(bus.pc), 32'h0000);
        bus.fetch_en = 1'b0;
        repeat (10) @(negedge clk);

        // 6: HALT word stops fetching until reset
        do_reset();
        mem[16'h0002] = 32'hF000_0000;
        bus.fetch_en  = 1'b1;
        n = 0;
        while (!bus.halted && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("halted", 32'(bus.halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.br_load = (i == 5);
            bus.br_addr = 16'h0010;
            check("halt_no_rd", 32'(bus.imem_rd), 32'd0);
        end
        bus.br_load = 1'b0;
        do_reset();
        @(negedge clk);
        check("halt_cleared", 32'(bus.halted), 32'd0);

        // 7: random fetch / take / branch traffic
        mem.delete();
        do_reset();
        rand_delay = 1'b1;
        take_pct   = 60;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            bus.fetch_en = ($urandom_range(0, 9) != 0);
            bus.br_load  = ($urandom_range(0, 19) == 0);
            bus.br_rel   = 1'($urandom_range(0, 1));
            bus.br_addr  = 16'($urandom);
        end
        @(negedge clk);
        bus.fetch_en = 1'b0;
        bus.br_load  = 1'b0;
        take_pct     = 100;
        repeat (20) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
